// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared FP32 constants, field helpers and accumulator state type
package fp32_pkg;

  localparam int          FP32_BIAS     = 127;
  localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;
  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_POS_INF  = 32'h7F80_0000;

  // Working mantissa: hidden 1 + 23 fraction bits + 3 guard bits
  localparam int          FP32_MANT_W   = 27;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

  function automatic logic fp32_sign(input logic [31:0] v);
    return v[31];
  endfunction

  function automatic logic [7:0] fp32_exp(input logic [31:0] v);
    return v[30:23];
  endfunction

  function automatic logic [22:0] fp32_frac(input logic [31:0] v);
    return v[22:0];
  endfunction

endpackage

// File: rtl/fp32_add_trunc.sv
// rtl/fp32_add_trunc.sv - combinational FP32 adder, flush-to-zero, truncating, overflow to Inf
module fp32_add_trunc
  import fp32_pkg::*;
(
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic [31:0] z_o
);

  localparam int MW = FP32_MANT_W;

  logic          sx, sy;
  logic [7:0]    ex, ey;
  logic [22:0]   fx, fy;
  logic          x_zero, y_zero, x_inf, y_inf;
  logic          x_big;
  logic          s_big;
  logic [7:0]    e_big, e_small, diff;
  logic [MW-1:0] m_big, m_small, m_small_sh;
  logic [MW:0]   sum_w;
  logic [MW-1:0] dif_w, norm;
  logic [4:0]    lz;
  logic [8:0]    exp_inc;
  logic signed [9:0] exp_sub;
  logic          unused_bits;

  // Leading-zero count over the 27-bit working mantissa (27 when all zero)
  function automatic logic [4:0] lzc27(input logic [MW-1:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] inf_of(input logic s);
    return FP32_POS_INF | {s, 31'd0};
  endfunction

  assign sx = fp32_sign(x_i);
  assign sy = fp32_sign(y_i);
  assign ex = fp32_exp(x_i);
  assign ey = fp32_exp(y_i);
  assign fx = fp32_frac(x_i);
  assign fy = fp32_frac(y_i);

  // Zero exponent means zero or subnormal; both flush to signed zero
  assign x_zero = (ex == 8'd0);
  assign y_zero = (ey == 8'd0);
  assign x_inf  = (ex == FP32_EXP_MAX);
  assign y_inf  = (ey == FP32_EXP_MAX);

  // Magnitude ordering; ties pick x so an exact cancellation keeps x as the big operand
  assign x_big   = ({ex, fx} >= {ey, fy});
  assign s_big   = x_big ? sx : sy;
  assign e_big   = x_big ? ex : ey;
  assign e_small = x_big ? ey : ex;
  assign m_big   = x_big ? {1'b1, fx, 3'b000} : {1'b1, fy, 3'b000};
  assign m_small = x_big ? {1'b1, fy, 3'b000} : {1'b1, fx, 3'b000};
  assign diff    = e_big - e_small;

  assign m_small_sh = (diff >= 8'd27) ? '0 : (m_small >> diff);

  assign sum_w   = {1'b0, m_big} + {1'b0, m_small_sh};
  assign dif_w   = m_big - m_small_sh;
  assign lz      = lzc27(dif_w);
  assign norm    = dif_w << lz;
  assign exp_inc = {1'b0, e_big} + 9'd1;
  assign exp_sub = $signed({2'b00, e_big}) - $signed({5'd0, lz});

  // Guard bits and the normalized hidden bit are dropped by truncation
  assign unused_bits = ^{sum_w[2:0], norm[MW-1], norm[2:0]};

  // Special cases first, then effective add or effective subtract
  always_comb begin
    z_o = FP32_POS_ZERO;
    if (x_inf) begin
      z_o = inf_of(sx);
    end else if (y_inf) begin
      z_o = inf_of(sy);
    end else if (x_zero && y_zero) begin
      z_o = {sx & sy, 31'd0};
    end else if (x_zero) begin
      z_o = y_i;
    end else if (y_zero) begin
      z_o = x_i;
    end else if (sx == sy) begin
      if (sum_w[MW]) begin
        if (exp_inc >= 9'd255) z_o = inf_of(s_big);
        else                   z_o = {s_big, exp_inc[7:0], sum_w[26:4]};
      end else begin
        z_o = {s_big, e_big, sum_w[25:3]};
      end
    end else begin
      if (dif_w == '0)               z_o = FP32_POS_ZERO;
      else if (exp_sub <= 10'sd0)    z_o = {s_big, 31'd0};
      else                           z_o = {s_big, exp_sub[7:0], norm[25:3]};
    end
  end

endmodule

// File: rtl/fp32_acc.sv
// rtl/fp32_acc.sv - framed FP32 running-sum accumulator fed by the PE multiplier
module fp32_acc
  import fp32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             first_in,
  input  logic             last_in,
  input  logic [31:0]      data_in,
  output logic             valid_out,
  output logic [31:0]      sum_out,
  output logic [CNT_W-1:0] count_out,
  output logic             busy,
  output logic             proto_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  acc_state_t       state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      add_x, add_z;
  logic             start;
  logic             proto_err_d;
  logic             valid_out_q, proto_err_q;
  logic [31:0]      sum_q;
  logic [CNT_W-1:0] count_q;

  // A beat opens a new sum when flagged first, or when no sum is open
  assign start = first_in | (state_q == IDLE);
  assign add_x = start ? FP32_POS_ZERO : acc_q;

  fp32_add_trunc u_add (
    .x_i (add_x),
    .y_i (data_in),
    .z_o (add_z)
  );

  // Next-state for the accumulator, counter, framing state and error flag
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    proto_err_d = 1'b0;
    if (valid_in) begin
      acc_d       = add_z;
      state_d     = last_in ? IDLE : ACCUM;
      proto_err_d = (state_q == IDLE) ? !first_in : first_in;
      if (start)                cnt_d = CNT_ONE;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    end
  end

  // FSM, accumulator and registered result; reset drops any partial sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= FP32_POS_ZERO;
      cnt_q       <= '0;
      valid_out_q <= 1'b0;
      proto_err_q <= 1'b0;
      sum_q       <= FP32_POS_ZERO;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
      valid_out_q <= valid_in & last_in;
      if (valid_in && last_in) begin
        sum_q   <= acc_d;
        count_q <= cnt_d;
      end
    end
  end

  assign valid_out = valid_out_q;
  assign sum_out   = sum_q;
  assign count_out = count_q;
  assign busy      = (state_q == ACCUM);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_fp32_acc.sv
// tb/tb_fp32_acc.sv - table-driven bench for the framed FP32 accumulator
module tb_fp32_acc;
  import fp32_pkg::*;

  localparam int CW = 3;
  localparam logic [31:0] ONE = {1'b0, 8'(FP32_BIAS), 23'd0};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in, first_in, last_in;
  logic [31:0]   data_in;
  logic          valid_out, busy, proto_err;
  logic [31:0]   sum_out;
  logic [CW-1:0] count_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          v, f, l;
    logic [31:0]   d;
    logic          vo;
    logic [31:0]   s;
    logic [CW-1:0] c;
    logic          b, e;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  fp32_acc #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .first_in  (first_in),
    .last_in   (last_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .sum_out   (sum_out),
    .count_out (count_out),
    .busy      (busy),
    .proto_err (proto_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic row(input logic v, input logic f, input logic l, input logic [31:0] d,
                     input logic vo, input logic [31:0] s, input int c,
                     input logic b, input logic e);
    vec_t r;
    r.v = v; r.f = f; r.l = l; r.d = d;
    r.vo = vo; r.s = s; r.c = CW'(c); r.b = b; r.e = e;
    tbl.push_back(r);
  endtask

  task automatic beat(input logic v, input logic f, input logic l, input logic [31:0] d);
    valid_in = v; first_in = f; last_in = l; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic vo, input logic [31:0] s,
                         input logic [CW-1:0] c, input logic b, input logic e);
    chk({tag, " valid_out"}, 32'(valid_out), 32'(vo));
    chk({tag, " sum_out"},   sum_out,        s);
    chk({tag, " count_out"}, 32'(count_out), 32'(c));
    chk({tag, " busy"},      32'(busy),      32'(b));
    chk({tag, " proto_err"}, 32'(proto_err), 32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // v f l data        vo sum           cnt busy err
    row(1, 1, 0, ONE,          0, 32'h00000000, 0, 1, 0);
    row(1, 0, 0, 32'h40000000, 0, 32'h00000000, 0, 1, 0);
    row(1, 0, 1, 32'h3FC00000, 1, 32'h40900000, 3, 0, 0);
    row(0, 0, 0, 32'h00000000, 0, 32'h40900000, 3, 0, 0);
    row(1, 1, 0, 32'h3F800000, 0, 32'h40900000, 3, 1, 0);
    row(1, 0, 1, 32'hBF800000, 1, 32'h00000000, 2, 0, 0);
    row(1, 1, 1, 32'h00000001, 1, 32'h00000000, 1, 0, 0);
    row(1, 1, 0, 32'h7F7FFFFF, 0, 32'h00000000, 1, 1, 0);
    row(1, 0, 0, 32'h7F7FFFFF, 0, 32'h00000000, 1, 1, 0);
    row(1, 0, 1, 32'h3F800000, 1, 32'h7F800000, 3, 0, 0);
    row(1, 1, 0, 32'h3F800000, 0, 32'h7F800000, 3, 1, 0);
    row(1, 0, 1, 32'h30800000, 1, 32'h3F800000, 2, 0, 0);
    row(1, 1, 0, 32'h3F800000, 0, 32'h3F800000, 2, 1, 0);
    row(1, 0, 1, 32'h33800000, 1, 32'h3F800000, 2, 0, 0);
    row(1, 0, 0, 32'h40000000, 0, 32'h3F800000, 2, 1, 1);
    row(1, 0, 0, 32'h3F800000, 0, 32'h3F800000, 2, 1, 0);
    row(0, 0, 0, 32'hDEADBEEF, 0, 32'h3F800000, 2, 1, 0);
    row(1, 1, 0, 32'h3F800000, 0, 32'h3F800000, 2, 1, 1);
    row(1, 0, 1, 32'h40400000, 1, 32'h40800000, 2, 0, 0);
    row(1, 0, 1, 32'h3F800000, 1, 32'h3F800000, 1, 0, 1);
    row(1, 1, 0, 32'h3F800000, 0, 32'h3F800000, 1, 1, 0);
    row(1, 0, 1, 32'hBF400000, 1, 32'h3E800000, 2, 0, 0);
    row(1, 1, 0, 32'h3F800000, 0, 32'h3E800000, 2, 1, 0);
    row(1, 0, 1, 32'hC0000000, 1, 32'hBF800000, 2, 0, 0);
    row(1, 1, 0, 32'h00C00000, 0, 32'hBF800000, 2, 1, 0);
    row(1, 0, 1, 32'h80800000, 1, 32'h00000000, 2, 0, 0);
    row(1, 1, 0, 32'h7F800000, 0, 32'h00000000, 2, 1, 0);
    row(1, 0, 1, 32'hFF800000, 1, 32'h7F800000, 2, 0, 0);

    rst_n = 1'b0; valid_in = 1'b0; first_in = 1'b0; last_in = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      beat(tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].d);
      chk_out($sformatf("row%0d", i), tbl[i].vo, tbl[i].s, tbl[i].c, tbl[i].b, tbl[i].e);
    end

    // Counter saturation: nine terms into a 3-bit counter
    beat(1, 1, 0, ONE);
    for (int k = 0; k < 7; k++) beat(1, 0, 0, ONE);
    beat(1, 0, 1, ONE);
    chk_out("saturate", 1'b1, 32'h41100000, CW'(7), 1'b0, 1'b0);

    // Asynchronous reset in the middle of a sum
    beat(1, 1, 0, ONE);
    beat(1, 0, 0, ONE);
    chk("midsum busy", 32'(busy), 32'd1);
    valid_in = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_out("async_reset", 1'b0, 32'h0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1, 1, 1, ONE);
    chk_out("after_reset", 1'b1, 32'h3F800000, CW'(1), 1'b0, 1'b0);
    beat(0, 0, 0, 32'h0);
    chk_out("after_reset_idle", 1'b0, 32'h3F800000, CW'(1), 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
